operand_fork: RTL and testbench

- Split stage for the ALU FIFO datapath: the inverse of the two-operand join in front of the adder.
- Takes one packed operand-pair stream (B in upper half, A in lower half) and delivers A and B on two independent valid/ready channels.
- Each branch has a 2-entry buffer, so one operand consumer may stall without blocking the other until its buffer fills.
- Sits between the operand source FIFO and the adder's in_A/in_B ports.

---
 rtl/operand_fork_pkg.sv | 18 +
 rtl/fork_branch_buf.sv | 74 +++++++
 rtl/operand_fork.sv | 67 ++++++
 tb/tb_operand_fork.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/operand_fork_pkg.sv
// operand_fork_pkg
//   Shared widths and types for the operand fork stage that splits a packed
//   {B, A} operand pair into two independent valid/ready channels.
//   No ports; imported by fork_branch_buf and operand_fork.
package operand_fork_pkg;

  localparam int DATA_IN_WIDTH = 8;
  localparam int PAIR_WIDTH    = 2 * DATA_IN_WIDTH;
  localparam int BUF_DEPTH     = 2;

  typedef logic [DATA_IN_WIDTH-1:0] operand_t;

  typedef struct packed {
    operand_t b;
    operand_t a;
  } pair_t;

endpackage

// File: rtl/fork_branch_buf.sv
// fork_branch_buf
//   Two-entry synchronous FIFO holding one operand branch of the fork.
//   Ports:
//     clk_i, rst_i  clock, synchronous active-high reset
//     push_i        write data_i into the tail slot
//     data_i        operand to store
//     pop_i         consumer takes the head word (ignored while empty)
//     full_o        both slots occupied
//     valid_o       at least one slot occupied
//     data_o        head word (slot at the read pointer)
//     occ_o         occupancy, 0..2
module fork_branch_buf
  import operand_fork_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       occ_o
);

  localparam logic [1:0] OCC_FULL = 2'(BUF_DEPTH);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             push_eff;
  logic             pop_eff;

  assign full_o  = (occ_q == OCC_FULL);
  assign valid_o = (occ_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign occ_o   = occ_q;

  // Gate locally as well so a stray push into a full buffer or a pop from an
  // empty one can never corrupt the pointers.
  assign push_eff = push_i & ~full_o;
  assign pop_eff  = pop_i & valid_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_eff) wr_ptr_d = ~wr_ptr_q;
    if (pop_eff)  rd_ptr_d = ~rd_ptr_q;
    case ({push_eff, pop_eff})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_eff) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/operand_fork.sv
// operand_fork
//   Splits one packed operand-pair stream ({B, A}) into two independent
//   valid/ready channels, each backed by a 2-entry buffer so one consumer
//   can stall without blocking the other until its buffer fills.
//   Ports:
//     clk_i, rst_i               clock, synchronous active-high reset
//     in_data/in_valid/in_ready  packed pair input {B, A}
//     out_A/out_A_valid/out_A_ready  operand A channel
//     out_B/out_B_valid/out_B_ready  operand B channel
//     occ_A, occ_B               per-branch buffer occupancy, 0..2
module operand_fork #(
  parameter int DATA_IN_WIDTH = operand_fork_pkg::DATA_IN_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [2*DATA_IN_WIDTH-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_IN_WIDTH-1:0]   out_A,
  output logic                       out_A_valid,
  input  logic                       out_A_ready,
  output logic [DATA_IN_WIDTH-1:0]   out_B,
  output logic                       out_B_valid,
  input  logic                       out_B_ready,
  output logic [1:0]                 occ_A,
  output logic [1:0]                 occ_B
);

  import operand_fork_pkg::*;

  logic full_a, full_b;
  logic push;

  // in_ready looks only at registered fullness, so downstream ready never
  // ripples back to the source combinationally. Both halves go together.
  assign in_ready = ~full_a & ~full_b & ~rst_i;
  assign push     = in_valid & in_ready;

  fork_branch_buf #(
    .WIDTH (DATA_IN_WIDTH)
  ) u_buf_a (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (in_data[DATA_IN_WIDTH-1:0]),
    .pop_i   (out_A_ready),
    .full_o  (full_a),
    .valid_o (out_A_valid),
    .data_o  (out_A),
    .occ_o   (occ_A)
  );

  fork_branch_buf #(
    .WIDTH (DATA_IN_WIDTH)
  ) u_buf_b (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (in_data[2*DATA_IN_WIDTH-1:DATA_IN_WIDTH]),
    .pop_i   (out_B_ready),
    .full_o  (full_b),
    .valid_o (out_B_valid),
    .data_o  (out_B),
    .occ_o   (occ_B)
  );

endmodule

// File: tb/tb_operand_fork.sv
module tb_operand_fork;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_A;
  logic        out_A_valid;
  logic        out_A_ready;
  logic [7:0]  out_B;
  logic        out_B_valid;
  logic        out_B_ready;
  logic [1:0]  occ_A;
  logic [1:0]  occ_B;

  int checks   = 0;
  int failures = 0;

  operand_fork dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_A       (out_A),
    .out_A_valid (out_A_valid),
    .out_A_ready (out_A_ready),
    .out_B       (out_B),
    .out_B_valid (out_B_valid),
    .out_B_ready (out_B_ready),
    .occ_A       (occ_A),
    .occ_B       (occ_B)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Check the full visible state of both branches.
  task automatic chk_state(input string tag,
                           input logic va, input logic [7:0] a, input logic [1:0] oa,
                           input logic vb, input logic [7:0] b, input logic [1:0] ob,
                           input logic rdy);
    chk({tag, "_vA"}, 16'(out_A_valid), 16'(va));
    if (va) chk({tag, "_A"}, 16'(out_A), 16'(a));
    chk({tag, "_occA"}, 16'(occ_A), 16'(oa));
    chk({tag, "_vB"}, 16'(out_B_valid), 16'(vb));
    if (vb) chk({tag, "_B"}, 16'(out_B), 16'(b));
    chk({tag, "_occB"}, 16'(occ_B), 16'(ob));
    chk({tag, "_rdy"}, 16'(in_ready), 16'(rdy));
  endtask

  initial begin
    // Reset held two cycles with in_valid asserted.
    rst_i = 1'b1; in_valid = 1'b1; in_data = 16'h0201;
    out_A_ready = 1'b1; out_B_ready = 1'b1;
    tick(); tick();
    chk_state("rst", 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0);
    chk("rst_outA", 16'(out_A), 16'h0000);
    chk("rst_outB", 16'(out_B), 16'h0000);
    rst_i = 1'b0; in_valid = 1'b0;
    #1;
    chk("rel_rdy", 16'(in_ready), 16'h0001);

    // Streaming with both consumers ready.
    in_valid = 1'b1; in_data = 16'h0201;
    tick(); chk_state("str1", 1'b1, 8'h01, 2'd1, 1'b1, 8'h02, 2'd1, 1'b1);
    in_data = 16'h0403;
    tick(); chk_state("str2", 1'b1, 8'h03, 2'd1, 1'b1, 8'h04, 2'd1, 1'b1);
    in_data = 16'h0605;
    tick(); chk_state("str3", 1'b1, 8'h05, 2'd1, 1'b1, 8'h06, 2'd1, 1'b1);
    in_valid = 1'b0;
    tick(); chk_state("str4", 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 1'b1);

    // Branch B stalls, A keeps draining.
    out_B_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0201;
    tick(); chk_state("stl1", 1'b1, 8'h01, 2'd1, 1'b1, 8'h02, 2'd1, 1'b1);
    in_data = 16'h0403;
    tick(); chk_state("stl2", 1'b1, 8'h03, 2'd1, 1'b1, 8'h02, 2'd2, 1'b0);
    in_data = 16'h0605;
    tick(); chk_state("stl3", 1'b0, 8'h00, 2'd0, 1'b1, 8'h02, 2'd2, 1'b0);
    out_B_ready = 1'b1;
    #1;
    chk("stl_rdy_reg", 16'(in_ready), 16'h0000);
    tick(); chk_state("stl4", 1'b0, 8'h00, 2'd0, 1'b1, 8'h04, 2'd1, 1'b1);
    tick(); chk_state("stl5", 1'b1, 8'h05, 2'd1, 1'b1, 8'h06, 2'd1, 1'b1);
    in_valid = 1'b0;
    tick(); chk_state("stl6", 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 1'b1);

    // Simultaneous push/pop at occupancy 1 across pointer wrap.
    in_valid = 1'b1; in_data = 16'h0807;
    tick(); chk_state("wrp1", 1'b1, 8'h07, 2'd1, 1'b1, 8'h08, 2'd1, 1'b1);
    in_data = 16'h0A09;
    tick(); chk_state("wrp2", 1'b1, 8'h09, 2'd1, 1'b1, 8'h0A, 2'd1, 1'b1);
    in_data = 16'h0C0B;
    tick(); chk_state("wrp3", 1'b1, 8'h0B, 2'd1, 1'b1, 8'h0C, 2'd1, 1'b1);
    in_valid = 1'b0;
    tick(); chk_state("wrp4", 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 1'b1);

    // Mid-operation reset with occA=2, occB=1.
    out_A_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h2211;
    tick(); chk_state("mrs1", 1'b1, 8'h11, 2'd1, 1'b1, 8'h22, 2'd1, 1'b1);
    in_data = 16'h4433;
    tick(); chk_state("mrs2", 1'b1, 8'h11, 2'd2, 1'b1, 8'h44, 2'd1, 1'b0);
    in_valid = 1'b0; rst_i = 1'b1;
    #1;
    chk("mrs_rdy_rst", 16'(in_ready), 16'h0000);
    tick(); chk_state("mrs3", 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0);
    chk("mrs3_outA", 16'(out_A), 16'h0000);
    chk("mrs3_outB", 16'(out_B), 16'h0000);
    rst_i = 1'b0; out_A_ready = 1'b1;
    tick(); chk_state("mrs4", 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 1'b1);

    // Backpressure stability on branch A.
    out_A_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'hBBAA;
    tick();
    in_valid = 1'b0;
    chk_state("bp0", 1'b1, 8'hAA, 2'd1, 1'b1, 8'hBB, 2'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_vA", 16'(out_A_valid), 16'h0001);
      chk("bp_A", 16'(out_A), 16'h00AA);
    end
    chk("bp_vB", 16'(out_B_valid), 16'h0000);
    out_A_ready = 1'b1;
    tick(); chk_state("bp_end", 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
